sobel_mem_arbiter: RTL and testbench

Shares the single memory port of the Sobel accelerator between the control unit's window-fetch read channel (72-bit, 3x3 pixels) and its result write channel (16-bit gradient). Both channels use a level req / single-cycle ack handshake, and the downstream memory uses the same handshake. The block provides round-robin arbitration, latches the address and data at grant, registers responses, and applies a watchdog timeout so that a dead memory cannot hang the sequencer.

---
 rtl/sobel_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sobel_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_mem_arbiter.sv
// sobel_mem_arbiter: shares the single memory port between the window-fetch
// read channel and the gradient write channel. Level req / one-cycle ack on
// all sides. Round-robin by default; defining SOBEL_ARB_WR_PRIO_EN switches
// to fixed write priority. A watchdog aborts a memory access that is never
// acknowledged (TIMEOUT_CYCLES = 0 disables it).
//
// Handshake: a requester raises req with stable addr/data and holds it until
// it sees a one-cycle ack. m_req is held from the cycle after the grant
// decision until m_ack is sampled or the watchdog fires. m_ack is honoured
// only while m_req is high.
module sobel_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int RDATA_W        = 72,
  parameter int WDATA_W        = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_ack,
  output logic [RDATA_W-1:0] rd_rdata,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WDATA_W-1:0] wr_wdata,
  output logic               wr_ack,
  output logic               m_req,
  output logic               m_we,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [WDATA_W-1:0] m_wdata,
  input  logic [RDATA_W-1:0] m_rdata,
  input  logic               m_ack,
  output logic               busy,
  output logic               timeout_err,
  output logic               err_sticky,
  input  logic               err_clr,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort in the last permitted waiting cycle so m_req is high for exactly
  // TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WDATA_W-1:0]   wdata_q, wdata_d;
  logic [RDATA_W-1:0]   rdata_q, rdata_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic                 err_set;
  logic                 pick_wr;

`ifdef SOBEL_ARB_WR_PRIO_EN
  // Fixed priority: pending results always drain before new windows.
  always_comb begin
    pick_wr = wr_req;
  end
`else
  logic last_wr_q, last_wr_d;

  // Round-robin: on contention, grant the channel not served last.
  always_comb begin
    pick_wr = wr_req && (!rd_req || !last_wr_q);
  end
`endif

  // Next-state, latching and watchdog logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    err_set = 1'b0;
`ifndef SOBEL_ARB_WR_PRIO_EN
    last_wr_d = last_wr_q;
`endif
    case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          we_d    = pick_wr;
          addr_d  = pick_wr ? wr_addr : rd_addr;
          if (pick_wr) wdata_d = wr_wdata;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (m_ack) begin
          if (!we_q) rdata_d = m_rdata;
          state_d = RESP;
        end else if (WD_EN && (cnt_q == CNT_LAST)) begin
          if (!we_q) rdata_d = '0;
          abort_d = 1'b1;
          err_set = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
`ifndef SOBEL_ARB_WR_PRIO_EN
        last_wr_d = we_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new timeout takes precedence over a simultaneous clear.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
`ifndef SOBEL_ARB_WR_PRIO_EN
      last_wr_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      err_q   <= err_d;
`ifndef SOBEL_ARB_WR_PRIO_EN
      last_wr_q <= last_wr_d;
`endif
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    m_req       = (state_q == GRANT);
    m_we        = we_q;
    m_addr      = addr_q;
    m_wdata     = wdata_q;
    rd_rdata    = rdata_q;
    rd_ack      = (state_q == RESP) && !we_q;
    wr_ack      = (state_q == RESP) && we_q;
    timeout_err = (state_q == RESP) && abort_q;
    busy        = (state_q != IDLE);
    err_sticky  = err_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_sobel_mem_arbiter.sv
// Bench for sobel_mem_arbiter: directed cases from the block description plus
// randomized single/contended transactions checked against a
// transaction-level arbitration model and a behavioural memory responder.
module tb_sobel_mem_arbiter;
  localparam int AW = 32;
  localparam int RW = 72;
  localparam int WW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack;
  logic [RW-1:0] rd_rdata;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [WW-1:0] wr_wdata = '0;
  logic          wr_ack;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_wdata;
  logic [RW-1:0] m_rdata;
  logic          m_ack;
  logic          busy, timeout_err, err_sticky;
  logic          err_clr = 1'b0;
  logic [1:0]    dbg_state_o;

  sobel_mem_arbiter #(.ADDR_W(AW), .RDATA_W(RW), .WDATA_W(WW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_ack(wr_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .timeout_err(timeout_err), .err_sticky(err_sticky),
    .err_clr(err_clr), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [AW:0] exp_q[$];     // {owner_is_write, address}
  bit model_last_wr = 1'b1;  // last-served channel, "write" after reset

  // memory responder controls and log
  int            mem_delay = 1;
  bit            mem_dead  = 1'b0;
  bit            mem_rand  = 1'b1;
  logic [RW-1:0] mem_data  = '0;
  int            spur_cnt  = 0;
  int            spur_done = 0;
  logic          log_we = 1'b0;
  logic [AW-1:0] log_addr = '0;
  logic [WW-1:0] log_wdata = '0;
  logic [RW-1:0] last_rdata = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected owner from the arbitration rule: write priority build picks any
  // pending write; round-robin picks the channel not served last.
  function automatic bit model_pick(input bit r, input bit w);
`ifdef SOBEL_ARB_WR_PRIO_EN
    if (r && w) return 1'b1;
    return w;
`else
    if (r && w) return !model_last_wr;
    return w;
`endif
  endfunction

  // Memory: logs each new m_req, acks mem_delay cycles later unless dead,
  // and can emit spurious acks while idle.
  initial begin
    int  cnt;
    bit  busy_m;
    cnt = 0;
    busy_m = 1'b0;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      m_ack = 1'b0;
      if (busy_m) begin
        if (!m_req) busy_m = 1'b0;
        else if (!mem_dead) begin
          if (cnt == 0) begin
            last_rdata = mem_rand ? RW'({$urandom(), $urandom(), $urandom()}) : mem_data;
            m_rdata = last_rdata;
            m_ack = 1'b1;
            busy_m = 1'b0;
          end else cnt--;
        end
      end else if (m_req) begin
        busy_m = 1'b1;
        cnt = mem_delay - 1;
        log_we = m_we;
        log_addr = m_addr;
        log_wdata = m_wdata;
      end else if (spur_cnt != spur_done) begin
        m_ack = 1'b1;
        m_rdata = RW'({$urandom(), $urandom(), $urandom()});
        spur_done++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(output int cyc, output logic gr, output logic gw);
    bit found;
    found = 1'b0;
    cyc = 0;
    gr = 1'b0;
    gw = 1'b0;
    for (int i = 1; i <= 100 && !found; i++) begin
      @(negedge clk);
      if (rd_ack || wr_ack) begin
        found = 1'b1;
        cyc = i;
        gr = rd_ack;
        gw = wr_ack;
      end
    end
    if (!found) check("ack_wait", 1'b0, 1'b1);
  endtask

  task automatic run_txn(input bit rd_en, input bit wr_en);
    int d, cyc, left;
    logic gr, gw;
    logic [AW:0] e;
    bit first, ow;
    @(negedge clk);
    d = $urandom_range(1, 5);
    mem_delay = d;
    mem_rand = 1'b1;
    rd_addr = $urandom();
    wr_addr = $urandom();
    wr_wdata = WW'($urandom());
    ow = model_pick(rd_en, wr_en);
    exp_q.push_back({ow, ow ? wr_addr : rd_addr});
    if (rd_en && wr_en) exp_q.push_back({!ow, !ow ? wr_addr : rd_addr});
    rd_req = rd_en;
    wr_req = wr_en;
    left = int'(rd_en) + int'(wr_en);
    first = 1'b1;
    while (left > 0) begin
      wait_ack(cyc, gr, gw);
      e = exp_q.pop_front();
      check("txn_owner", gw, e[AW]);
      check("txn_we", log_we, e[AW]);
      check("txn_addr", log_addr, e[AW-1:0]);
      if (gw) check("txn_wdata", log_wdata, wr_wdata);
      else    check("txn_rdata", rd_rdata, last_rdata);
      if (first) check("txn_latency", cyc, 2 + d);
      model_last_wr = e[AW];
      if (gw) wr_req = 1'b0;
      else    rd_req = 1'b0;
      first = 1'b0;
      left--;
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, n_mreq;
    logic gr, gw;
    bit exp_wr, done;

    // reset
    repeat (3) @(negedge clk);
    check("rst_rd_ack", rd_ack, 1'b0);
    check("rst_wr_ack", wr_ack, 1'b0);
    check("rst_m_req", m_req, 1'b0);
    check("rst_m_we", m_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_err_sticky", err_sticky, 1'b0);
    check("rst_m_addr", m_addr, '0);
    check("rst_m_wdata", m_wdata, '0);
    check("rst_rd_rdata", rd_rdata, '0);
    check("rst_state", dbg_state_o, 2'd0);
    rst_n = 1'b1;

    // single read, memory acks one cycle after m_req
    @(negedge clk);
    mem_rand = 1'b0;
    mem_data = 72'h0A141E28323C46505A;
    mem_delay = 1;
    rd_addr = 32'h1000;
    rd_req = 1'b1;
    wait_ack(cyc, gr, gw);
    rd_req = 1'b0;
    check("rd_latency", cyc, 3);
    check("rd_ack", gr, 1'b1);
    check("rd_no_wr_ack", gw, 1'b0);
    check("rd_m_we", log_we, 1'b0);
    check("rd_m_addr", log_addr, 32'h1000);
    check("rd_rdata", rd_rdata, 72'h0A141E28323C46505A);
    model_last_wr = 1'b0;
    @(negedge clk);
    check("rd_ack_pulse", rd_ack, 1'b0);
    check("rd_idle_busy", busy, 1'b0);
    check("rd_data_hold", rd_rdata, 72'h0A141E28323C46505A);

    // single write
    wr_addr = 32'h2000;
    wr_wdata = 16'd123;
    wr_req = 1'b1;
    wait_ack(cyc, gr, gw);
    wr_req = 1'b0;
    check("wr_latency", cyc, 3);
    check("wr_ack", gw, 1'b1);
    check("wr_no_rd_ack", gr, 1'b0);
    check("wr_m_we", log_we, 1'b1);
    check("wr_m_addr", log_addr, 32'h2000);
    check("wr_m_wdata", log_wdata, 16'd123);
    model_last_wr = 1'b1;
    @(negedge clk);
    check("wr_ack_pulse", wr_ack, 1'b0);

    // contention: both held for four transactions, then write drops
    mem_rand = 1'b1;
    mem_delay = 2;
    rd_addr = 32'h3000;
    wr_addr = 32'h4000;
    wr_wdata = 16'h55AA;
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_wr = model_pick(rd_req, wr_req);
      wait_ack(cyc, gr, gw);
      check("cont_owner", gw, exp_wr);
      check("cont_single_ack", gr ^ gw, 1'b1);
      check("cont_addr", log_addr, exp_wr ? 32'h4000 : 32'h3000);
      model_last_wr = exp_wr;
      if (k == 3) wr_req = 1'b0;
      if (k == 4) rd_req = 1'b0;
    end

    // read timeout with dead memory
    @(negedge clk);
    mem_dead = 1'b1;
    rd_addr = 32'h5000;
    rd_req = 1'b1;
    n_mreq = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rd_ack || wr_ack) done = 1'b1;
      else if (m_req) n_mreq++;
    end
    check("to_done", done, 1'b1);
    check("to_mreq_cycles", n_mreq, TO);
    check("to_rd_ack", rd_ack, 1'b1);
    check("to_err_pulse", timeout_err, 1'b1);
    check("to_rdata_zero", rd_rdata, '0);
    check("to_sticky", err_sticky, 1'b1);
    rd_req = 1'b0;
    model_last_wr = 1'b0;
    @(negedge clk);
    check("to_err_one_cycle", timeout_err, 1'b0);
    check("to_sticky_hold", err_sticky, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_sticky_clr", err_sticky, 1'b0);

    // write timeout with err_clr held: set wins over clear
    err_clr = 1'b1;
    wr_addr = 32'h6000;
    wr_req = 1'b1;
    wait_ack(cyc, gr, gw);
    wr_req = 1'b0;
    check("to_wr_ack", gw, 1'b1);
    check("to_wr_cycles", cyc, TO + 1);
    check("to_wr_err", timeout_err, 1'b1);
    check("to_set_wins", err_sticky, 1'b1);
    model_last_wr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_clr_after", err_sticky, 1'b0);
    mem_dead = 1'b0;

    // randomized transactions against the model
    for (int it = 0; it < 16; it++) begin
      bit r, w;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      run_txn(r, w);
    end

    // reset mid-GRANT, then a late m_ack must be ignored
    @(negedge clk);
    mem_dead = 1'b1;
    rd_addr = 32'h7000;
    rd_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rmid_pre_mreq", m_req, 1'b1);
    rst_n = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    check("rmid_m_req", m_req, 1'b0);
    check("rmid_busy", busy, 1'b0);
    check("rmid_no_ack", rd_ack, 1'b0);
    rst_n = 1'b1;
    mem_dead = 1'b0;
    model_last_wr = 1'b1;
    spur_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_no_ack", rd_ack | wr_ack, 1'b0);
      check("late_ack_idle", dbg_state_o, 2'd0);
    end
    check("late_ack_seen", spur_done, spur_cnt);

    // last-served is back to "write" after reset: contended grant goes to read
    run_txn(1'b1, 1'b1);

    // spurious m_ack in IDLE
    spur_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_no_ack", rd_ack | wr_ack, 1'b0);
      check("spur_busy", busy, 1'b0);
    end
    run_txn(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
